// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: stage register addresses and control bits
// flow in, stall/flush/forward controls and status flow back out.
interface hazard_ctrl_if #(
    parameter int CW = 16
);
    logic [4:0]    RsD;
    logic [4:0]    RtD;
    logic [4:0]    RsE;
    logic [4:0]    RtE;
    logic [4:0]    WriteRegE;
    logic [4:0]    WriteRegM;
    logic [4:0]    WriteRegW;
    logic          RegWriteE;
    logic          RegWriteM;
    logic          RegWriteW;
    logic          MemtoRegE;
    logic          MemtoRegM;
    logic          BranchD;
    logic          JumpD;
    logic          PCSrcD;
    logic          dmem_req_M;
    logic          dmem_ready;

    logic          StallF;
    logic          StallD;
    logic          StallE;
    logic          StallM;
    logic          FlushD;
    logic          FlushE;
    logic          FlushW;
    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic          ForwardAD;
    logic          ForwardBD;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt;

    // Pipeline side: supplies stage information, consumes controls
    modport master (
        output RsD, RtD, RsE, RtE,
        output WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, MemtoRegM,
        output BranchD, JumpD, PCSrcD,
        output dmem_req_M, dmem_ready,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  mem_timeout, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  RsD, RtD, RsE, RtE,
        input  WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, MemtoRegM,
        input  BranchD, JumpD, PCSrcD,
        input  dmem_req_M, dmem_ready,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline.
// Combinational forwarding and stall/flush generation, plus a small FSM that
// tracks variable-latency data-memory waits, a watchdog that traps into a
// sticky error state, and a saturating count of fetch-stall cycles.
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [WW-1:0] r_wait_cnt;
    logic [WW-1:0] w_wait_nxt;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] w_stall_cnt_nxt;

    logic          w_lwstall;
    logic          w_branchstall;
    logic          w_mem_stall;
    logic          w_timeout_hit;

    logic [1:0]    w_fwd_ae;
    logic [1:0]    w_fwd_be;
    logic          w_fwd_ad;
    logic          w_fwd_bd;

    logic          w_stall_f;
    logic          w_stall_d;
    logic          w_stall_e;
    logic          w_stall_m;
    logic          w_flush_d;
    logic          w_flush_e;
    logic          w_flush_w;

    // E-stage operand select: the newer M result wins over the W result,
    // and register 0 is never forwarded since it always reads as zero.
    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] src,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        if (src != 5'd0 && reg_write_m && write_reg_m == src) begin
            return 2'b10;
        end else if (src != 5'd0 && reg_write_w && write_reg_w == src) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Operand forwarding for the ALU in E and the branch comparator in D
    always_comb begin
        w_fwd_ae = fwd_sel_e(bus.RsE, bus.RegWriteM, bus.WriteRegM,
                             bus.RegWriteW, bus.WriteRegW);
        w_fwd_be = fwd_sel_e(bus.RtE, bus.RegWriteM, bus.WriteRegM,
                             bus.RegWriteW, bus.WriteRegW);
        w_fwd_ad = (bus.RsD != 5'd0) && bus.RegWriteM && (bus.WriteRegM == bus.RsD);
        w_fwd_bd = (bus.RtD != 5'd0) && bus.RegWriteM && (bus.WriteRegM == bus.RtD);
    end

    // Raw hazard terms: load-use, branch-operand-not-ready, and memory wait
    always_comb begin
        w_lwstall = bus.MemtoRegE && (bus.RtE != 5'd0) &&
                    ((bus.RtE == bus.RsD) || (bus.RtE == bus.RtD));

        w_branchstall = bus.BranchD &&
            ((bus.RegWriteE && (bus.WriteRegE != 5'd0) &&
              ((bus.WriteRegE == bus.RsD) || (bus.WriteRegE == bus.RtD))) ||
             (bus.MemtoRegM && (bus.WriteRegM != 5'd0) &&
              ((bus.WriteRegM == bus.RsD) || (bus.WriteRegM == bus.RtD))));

        w_mem_stall   = bus.dmem_req_M && !bus.dmem_ready;
        w_timeout_hit = w_mem_stall && (r_wait_cnt == WW'(TIMEOUT - 1));
    end

    // Stall/flush priority: error trap, then memory wait (which freezes E so
    // a load-use bubble must wait), then data hazards, then control redirect
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (r_state == ERR) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
        end else if (w_mem_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_lwstall || w_branchstall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            w_flush_d = bus.PCSrcD | bus.JumpD;
        end
    end

    // Next state: enter MEMWAIT on a wait, leave it as soon as the wait ends,
    // and trap into ERR once the wait reaches the watchdog limit
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_timeout_hit) begin
                    w_state_nxt = ERR;
                end else if (w_mem_stall) begin
                    w_state_nxt = MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (!w_mem_stall) begin
                    w_state_nxt = RUN;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ERR;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Counter next values: wait length restarts whenever the wait breaks,
    // fetch-stall count sticks at its maximum instead of wrapping
    always_comb begin
        w_wait_nxt = '0;
        if (w_mem_stall) begin
            w_wait_nxt = (r_state == ERR) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end

        w_stall_cnt_nxt = r_stall_cnt;
        if (w_stall_f && (r_stall_cnt != {CW{1'b1}})) begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    // While in reset, D-to-E latch is cleared and everything else is released
    assign bus.StallF      = rst_n & w_stall_f;
    assign bus.StallD      = rst_n & w_stall_d;
    assign bus.StallE      = rst_n & w_stall_e;
    assign bus.StallM      = rst_n & w_stall_m;
    assign bus.FlushD      = rst_n & w_flush_d;
    assign bus.FlushE      = !rst_n | w_flush_e;
    assign bus.FlushW      = rst_n & w_flush_w;
    assign bus.ForwardAE   = rst_n ? w_fwd_ae : 2'b00;
    assign bus.ForwardBE   = rst_n ? w_fwd_be : 2'b00;
    assign bus.ForwardAD   = rst_n & w_fwd_ad;
    assign bus.ForwardBD   = rst_n & w_fwd_bd;
    assign bus.mem_timeout = (r_state == ERR);
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with a short watchdog and a 4-bit
// stall counter so the timeout and saturation corners are reached quickly.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   nChecks = 0;
    int   nBad    = 0;

    hazard_ctrl_if #(.CW(4)) hif ();

    hazard_ctrl #(
        .TIMEOUT(4),
        .CW     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (hif)
    );

    // Pipeline clock, rising edge at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Packed view of the seven latch controls: F D E M stalls, D E W flushes
    logic [6:0] ctl;
    assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                  hif.FlushD, hif.FlushE, hif.FlushW};

    localparam logic [6:0] CTL_IDLE   = 7'b0000000;
    localparam logic [6:0] CTL_RESET  = 7'b0000010;
    localparam logic [6:0] CTL_HAZARD = 7'b1100010;
    localparam logic [6:0] CTL_MEM    = 7'b1111001;
    localparam logic [6:0] CTL_ERR    = 7'b1111000;
    localparam logic [6:0] CTL_REDIR  = 7'b0000100;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Return every pipeline input to a hazard-free idle pattern
    task automatic clearInputs();
        hif.RsD        = 5'd0;
        hif.RtD        = 5'd0;
        hif.RsE        = 5'd0;
        hif.RtE        = 5'd0;
        hif.WriteRegE  = 5'd0;
        hif.WriteRegM  = 5'd0;
        hif.WriteRegW  = 5'd0;
        hif.RegWriteE  = 1'b0;
        hif.RegWriteM  = 1'b0;
        hif.RegWriteW  = 1'b0;
        hif.MemtoRegE  = 1'b0;
        hif.MemtoRegM  = 1'b0;
        hif.BranchD    = 1'b0;
        hif.JumpD      = 1'b0;
        hif.PCSrcD     = 1'b0;
        hif.dmem_req_M = 1'b0;
        hif.dmem_ready = 1'b0;
    endtask

    // Step to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Backstop so a stuck run still terminates
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] hazard_ctrl directed test start");
        rst_n = 1'b1;
        clearInputs();
        #1 rst_n = 1'b0;

        // Reset: FlushE forced, forwarding suppressed even with a match present
        hif.RsE       = 5'd3;
        hif.RegWriteM = 1'b1;
        hif.WriteRegM = 5'd3;
        #2;
        checkOutput("rst_ctl", ctl, CTL_RESET);
        checkOutput("rst_fwdAE", hif.ForwardAE, 2'b00);
        checkOutput("rst_cnt", hif.stall_cnt, 4'd0);
        checkOutput("rst_timeout", hif.mem_timeout, 1'b0);

        #9 rst_n = 1'b1;
        clearInputs();
        #1;
        checkOutput("idle_ctl", ctl, CTL_IDLE);

        // Forwarding priority
        nextCycle();
        hif.RsE       = 5'd3;
        hif.RtE       = 5'd4;
        hif.RegWriteM = 1'b1;
        hif.RegWriteW = 1'b1;
        hif.WriteRegM = 5'd3;
        hif.WriteRegW = 5'd3;
        #1;
        checkOutput("fwdAE_M", hif.ForwardAE, 2'b10);
        checkOutput("fwdBE_none", hif.ForwardBE, 2'b00);
        hif.RegWriteM = 1'b0;
        #1;
        checkOutput("fwdAE_W", hif.ForwardAE, 2'b01);
        hif.RsE = 5'd0;
        hif.WriteRegW = 5'd0;
        #1;
        checkOutput("fwdAE_r0", hif.ForwardAE, 2'b00);
        hif.RtE = 5'd9;
        hif.WriteRegW = 5'd9;
        #1;
        checkOutput("fwdBE_W", hif.ForwardBE, 2'b01);
        hif.RsD = 5'd3;
        hif.RegWriteM = 1'b1;
        hif.WriteRegM = 5'd3;
        #1;
        checkOutput("fwdAD", hif.ForwardAD, 1'b1);
        checkOutput("fwdBD_none", hif.ForwardBD, 1'b0);
        checkOutput("fwd_ctl", ctl, CTL_IDLE);

        // Load-use stall, then the same pattern with RtE = 0
        nextCycle();
        clearInputs();
        hif.MemtoRegE = 1'b1;
        hif.RtE       = 5'd5;
        hif.RsD       = 5'd5;
        #1;
        checkOutput("lw_ctl", ctl, CTL_HAZARD);
        nextCycle();
        checkOutput("lw_cnt", hif.stall_cnt, 4'd1);
        hif.RtE = 5'd0;
        #1;
        checkOutput("lw_r0_ctl", ctl, CTL_IDLE);
        nextCycle();
        checkOutput("lw_r0_cnt", hif.stall_cnt, 4'd1);

        // Branch hazards from E and from a load in M, then taken redirect
        clearInputs();
        hif.BranchD   = 1'b1;
        hif.RsD       = 5'd7;
        hif.RegWriteE = 1'b1;
        hif.WriteRegE = 5'd7;
        #1;
        checkOutput("br_E_ctl", ctl, CTL_HAZARD);
        nextCycle();
        hif.RegWriteE = 1'b0;
        hif.MemtoRegM = 1'b1;
        hif.WriteRegM = 5'd7;
        #1;
        checkOutput("br_M_ctl", ctl, CTL_HAZARD);
        nextCycle();
        clearInputs();
        hif.BranchD = 1'b1;
        hif.PCSrcD  = 1'b1;
        #1;
        checkOutput("br_taken_ctl", ctl, CTL_REDIR);
        hif.BranchD = 1'b0;
        hif.PCSrcD  = 1'b0;
        hif.JumpD   = 1'b1;
        #1;
        checkOutput("jump_ctl", ctl, CTL_REDIR);
        checkOutput("br_cnt", hif.stall_cnt, 4'd3);

        // Memory access completing immediately: no stall
        nextCycle();
        clearInputs();
        hif.dmem_req_M = 1'b1;
        hif.dmem_ready = 1'b1;
        #1;
        checkOutput("mem_fast_ctl", ctl, CTL_IDLE);

        // Three-cycle memory wait with a load-use hazard arriving mid-wait
        nextCycle();
        hif.dmem_ready = 1'b0;
        #1;
        checkOutput("mem_w1_ctl", ctl, CTL_MEM);
        nextCycle();
        hif.MemtoRegE = 1'b1;
        hif.RtE       = 5'd5;
        hif.RsD       = 5'd5;
        #1;
        checkOutput("mem_w2_lw_ctl", ctl, CTL_MEM);
        nextCycle();
        checkOutput("mem_w3_ctl", ctl, CTL_MEM);
        nextCycle();
        hif.dmem_ready = 1'b1;
        #1;
        checkOutput("mem_done_lw_ctl", ctl, CTL_HAZARD);
        nextCycle();
        clearInputs();
        #1;
        checkOutput("mem_after_ctl", ctl, CTL_IDLE);
        checkOutput("mem_cnt", hif.stall_cnt, 4'd7);
        checkOutput("mem_no_timeout", hif.mem_timeout, 1'b0);

        // Watchdog: four consecutive wait cycles trap into the error state
        nextCycle();
        hif.dmem_req_M = 1'b1;
        hif.dmem_ready = 1'b0;
        #1;
        checkOutput("to_w1_ctl", ctl, CTL_MEM);
        nextCycle();
        checkOutput("to_w2_ctl", ctl, CTL_MEM);
        nextCycle();
        checkOutput("to_w3_ctl", ctl, CTL_MEM);
        nextCycle();
        checkOutput("to_w4_ctl", ctl, CTL_MEM);
        checkOutput("to_w4_flag", hif.mem_timeout, 1'b0);
        nextCycle();
        checkOutput("err_ctl", ctl, CTL_ERR);
        checkOutput("err_flag", hif.mem_timeout, 1'b1);
        checkOutput("err_cnt", hif.stall_cnt, 4'd11);
        hif.dmem_ready = 1'b1;
        #1;
        checkOutput("err_ready_ctl", ctl, CTL_ERR);
        nextCycle();
        clearInputs();
        #1;
        checkOutput("err_hold_ctl", ctl, CTL_ERR);
        checkOutput("err_hold_flag", hif.mem_timeout, 1'b1);

        // Stall counter saturates at 15 while the error state holds stalls
        repeat (10) nextCycle();
        checkOutput("sat_cnt", hif.stall_cnt, 4'd15);

        // Asynchronous reset pulse mid-cycle clears error and counters
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_ctl", ctl, CTL_RESET);
        checkOutput("rst2_flag", hif.mem_timeout, 1'b0);
        checkOutput("rst2_cnt", hif.stall_cnt, 4'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst2_idle_ctl", ctl, CTL_IDLE);
        nextCycle();
        checkOutput("rst2_run_cnt", hif.stall_cnt, 4'd0);
        checkOutput("rst2_run_flag", hif.mem_timeout, 1'b0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
